// File: rtl/riscv_store_buffer.sv
// Posted-write store buffer between the memory stage and a req/ack data bus.
// Stores drain in order; loads that hit buffered words get the merged bytes forwarded.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_store_buffer #(
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_mem_write_m,
    input  logic [3:0]        i_mem_byte_sel_m,
    input  logic [`XLEN-1:0]  i_alu_result_m,
    input  logic [`XLEN-1:0]  i_write_data_m,
    input  logic              i_load_m,
    output logic              o_sb_stall,
    output logic [3:0]        o_load_hit_mask,
    output logic [`XLEN-1:0]  o_load_hit_data,
    output logic              o_empty,
    output logic              o_bus_req,
    output logic [`XLEN-1:0]  o_bus_addr,
    output logic [`XLEN-1:0]  o_bus_wdata,
    output logic [3:0]        o_bus_be,
    input  logic              i_bus_ack,
    output logic              o_dbg_state
);

    localparam int XL = `XLEN;
    localparam int AW = XL - 2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    // Bus handshake: o_bus_req and the bus fields are held until the cycle
    // i_bus_ack is seen high in REQ; that cycle completes the write.
    typedef enum logic {S_IDLE, S_REQ} state_t;
    state_t state;

    logic [AW-1:0]         ent_addr [DEPTH];
    logic [XL-1:0]         ent_data [DEPTH];
    logic [3:0]            ent_be   [DEPTH];
    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  full;
    logic                  enq;
    logic                  deq;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^i_alu_result_m[1:0];
    assign full = (count == FULL_CNT);
    // A full buffer refuses the store even when an ack frees a slot this cycle.
    assign enq  = i_mem_write_m & (i_mem_byte_sel_m != 4'b0) & ~full;
    assign deq  = (state == S_REQ) & i_bus_ack;
    assign o_dbg_state = (state == S_REQ);

    always_comb begin
        count_next = count;
        if (enq && !deq) begin
            count_next = count + 1'b1;
        end else if (!enq && deq) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_be[i]   <= '0;
            end
        end else begin
            if (enq) begin
                ent_addr[wr_ptr]  <= i_alu_result_m[XL-1:2];
                ent_data[wr_ptr]  <= i_write_data_m;
                ent_be[wr_ptr]    <= i_mem_byte_sel_m;
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (deq) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= S_IDLE;
            o_bus_req   <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_bus_be    <= '0;
            o_empty     <= 1'b1;
        end else begin
            o_empty <= (count_next == '0);
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        o_bus_addr  <= {ent_addr[rd_ptr], 2'b00};
                        o_bus_wdata <= ent_data[rd_ptr];
                        o_bus_be    <= ent_be[rd_ptr];
                        o_bus_req   <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_bus_ack) begin
                        o_bus_req <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Walk entries oldest to youngest so a younger store overwrites per lane.
    always_comb begin
        logic [DEPTH_LOG2-1:0] idx;
        idx             = '0;
        o_load_hit_mask = '0;
        o_load_hit_data = '0;
        if (i_load_m) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + DEPTH_LOG2'(i);
                if (ent_valid[idx] && (ent_addr[idx] == i_alu_result_m[XL-1:2])) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ent_be[idx][b]) begin
                            o_load_hit_mask[b]      = 1'b1;
                            o_load_hit_data[8*b+:8] = ent_data[idx][8*b+:8];
                        end
                    end
                end
            end
        end
    end

    assign o_sb_stall = (i_mem_write_m & (i_mem_byte_sel_m != 4'b0) & full)
                      | (i_load_m & (o_load_hit_mask != 4'b0)
                         & (o_load_hit_mask != i_mem_byte_sel_m));

endmodule

// File: tb/tb_riscv_store_buffer.sv
// Directed bench for riscv_store_buffer: forwarding vector table plus
// hand-written sequences for reset, fill/stall, partial hit and pointer wrap.
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_store_buffer;

    localparam int XL = `XLEN;
    localparam int W  = XL + XL + 4;

    logic           i_clk;
    logic           i_rstn;
    logic           i_mem_write_m;
    logic [3:0]     i_mem_byte_sel_m;
    logic [XL-1:0]  i_alu_result_m;
    logic [XL-1:0]  i_write_data_m;
    logic           i_load_m;
    logic           o_sb_stall;
    logic [3:0]     o_load_hit_mask;
    logic [XL-1:0]  o_load_hit_data;
    logic           o_empty;
    logic           o_bus_req;
    logic [XL-1:0]  o_bus_addr;
    logic [XL-1:0]  o_bus_wdata;
    logic [3:0]     o_bus_be;
    logic           i_bus_ack;
    logic           o_dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic          load;
        logic [XL-1:0] addr;
        logic [3:0]    lanes;
        logic [3:0]    exp_mask;
        logic [XL-1:0] exp_data;
        logic          exp_stall;
    } fwd_vec_t;

    riscv_store_buffer #(.DEPTH(4), .DEPTH_LOG2(2)) dut (
        .i_clk            (i_clk),
        .i_rstn           (i_rstn),
        .i_mem_write_m    (i_mem_write_m),
        .i_mem_byte_sel_m (i_mem_byte_sel_m),
        .i_alu_result_m   (i_alu_result_m),
        .i_write_data_m   (i_write_data_m),
        .i_load_m         (i_load_m),
        .o_sb_stall       (o_sb_stall),
        .o_load_hit_mask  (o_load_hit_mask),
        .o_load_hit_data  (o_load_hit_data),
        .o_empty          (o_empty),
        .o_bus_req        (o_bus_req),
        .o_bus_addr       (o_bus_addr),
        .o_bus_wdata      (o_bus_wdata),
        .o_bus_be         (o_bus_be),
        .i_bus_ack        (i_bus_ack),
        .o_dbg_state      (o_dbg_state)
    );

    // Clock / watchdog
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver and scoreboard tasks
    task automatic check(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_mem_write_m    = 1'b0;
        i_mem_byte_sel_m = 4'h0;
        i_alu_result_m   = '0;
        i_write_data_m   = '0;
        i_load_m         = 1'b0;
    endtask

    task automatic drive_store(input logic [XL-1:0] addr, input logic [XL-1:0] data, input logic [3:0] be);
        i_mem_write_m    = 1'b1;
        i_mem_byte_sel_m = be;
        i_alu_result_m   = addr;
        i_write_data_m   = data;
        i_load_m         = 1'b0;
    endtask

    task automatic push_exp(input logic [XL-1:0] addr, input logic [XL-1:0] data, input logic [3:0] be);
        exp_q.push_back({addr[XL-1:2], 2'b00, data, be});
    endtask

    // Called at a negedge; the store is captured on the following posedge.
    task automatic store(input logic [XL-1:0] addr, input logic [XL-1:0] data, input logic [3:0] be);
        drive_store(addr, data, be);
        push_exp(addr, data, be);
        @(negedge i_clk);
        idle_inputs();
    endtask

    task automatic check_head();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL bus_unexpected: got addr 0x%0h with no write expected", o_bus_addr);
        end else begin
            e = exp_q.pop_front();
            check("bus_addr", o_bus_addr, e[W-1 -: XL]);
            check("bus_wdata", o_bus_wdata, e[XL+3 -: XL]);
            check("bus_be", {28'h0, o_bus_be}, {28'h0, e[3:0]});
        end
    endtask

    // Called at a negedge: waits for a request, checks it, acks for one cycle.
    task automatic ack_one();
        int waited = 0;
        while (!o_bus_req && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_bus_req) begin
            n_cmp++;
            n_err++;
            $display("FAIL bus_req_timeout: got req 0 expected 1 within 20 cycles");
        end else begin
            check_head();
            i_bus_ack = 1'b1;
            @(negedge i_clk);
            i_bus_ack = 1'b0;
        end
    endtask

    initial begin
        fwd_vec_t vecs[7];
        int waited;

        i_rstn    = 1'b0;
        i_bus_ack = 1'b0;
        idle_inputs();
        repeat (2) @(negedge i_clk);

        // Reset values
        check("rst_req", {31'h0, o_bus_req}, 32'h0);
        check("rst_addr", o_bus_addr, 32'h0);
        check("rst_wdata", o_bus_wdata, 32'h0);
        check("rst_be", {28'h0, o_bus_be}, 32'h0);
        check("rst_empty", {31'h0, o_empty}, 32'h1);
        check("rst_stall", {31'h0, o_sb_stall}, 32'h0);
        i_rstn = 1'b1;
        @(negedge i_clk);

        // Reset in the middle of a bus request
        store(32'h0000_0040, 32'h1111_1111, 4'hF);
        check("req_not_same_cycle", {31'h0, o_bus_req}, 32'h0);
        store(32'h0000_0044, 32'h2222_2222, 4'hF);
        waited = 0;
        while (!o_bus_req && waited < 10) begin
            @(negedge i_clk);
            waited++;
        end
        check("rstmid_req_before", {31'h0, o_bus_req}, 32'h1);
        #2 i_rstn = 1'b0;
        #1;
        check("rstmid_req_drop", {31'h0, o_bus_req}, 32'h0);
        check("rstmid_empty", {31'h0, o_empty}, 32'h1);
        exp_q.delete();
        @(negedge i_clk);
        i_rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            check("rstmid_no_req", {31'h0, o_bus_req}, 32'h0);
        end
        check("rstmid_empty_after", {31'h0, o_empty}, 32'h1);

        // Single store
        store(32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        check("single_not_empty", {31'h0, o_empty}, 32'h0);
        ack_one();
        check("single_empty_after", {31'h0, o_empty}, 32'h1);
        @(negedge i_clk);

        // Fill: five back-to-back stores with ack held low
        for (int k = 0; k < 4; k++) begin
            store(XL'(4 * k), 32'hC0DE_0000 | XL'(k), 4'hF);
        end
        drive_store(32'h0000_0010, 32'hC0DE_0004, 4'hF);
        #1;
        check("fill_stall_full", {31'h0, o_sb_stall}, 32'h1);
        check("fill_req_up", {31'h0, o_bus_req}, 32'h1);
        @(negedge i_clk);
        #1;
        check("fill_stall_hold", {31'h0, o_sb_stall}, 32'h1);
        @(negedge i_clk);
        check_head();
        i_bus_ack = 1'b1;
        #1;
        check("fill_stall_on_ack", {31'h0, o_sb_stall}, 32'h1);
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        #1;
        check("fill_stall_after_ack", {31'h0, o_sb_stall}, 32'h0);
        push_exp(32'h0000_0010, 32'hC0DE_0004, 4'hF);
        @(negedge i_clk);
        idle_inputs();
        for (int k = 0; k < 4; k++) ack_one();
        check("fill_empty_end", {31'h0, o_empty}, 32'h1);
        check("fill_q_drained", 32'(exp_q.size()), 32'h0);

        // Forwarding table
        store(32'h0000_0200, 32'h1122_3344, 4'hF);
        store(32'h0000_0200, 32'h0000_00AA, 4'b0001);
        store(32'h0000_0204, 32'h5566_0000, 4'b1100);
        vecs[0] = '{1'b1, 32'h0000_0200, 4'hF,    4'hF,    32'h1122_33AA, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0202, 4'hF,    4'hF,    32'h1122_33AA, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0204, 4'b1100, 4'b1100, 32'h5566_0000, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0204, 4'hF,    4'b1100, 32'h5566_0000, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0208, 4'hF,    4'h0,    32'h0,         1'b0};
        vecs[5] = '{1'b0, 32'h0000_0200, 4'hF,    4'h0,    32'h0,         1'b0};
        vecs[6] = '{1'b1, 32'h0000_0200, 4'b0001, 4'hF,    32'h1122_33AA, 1'b1};
        for (int v = 0; v < 7; v++) begin
            i_mem_write_m    = 1'b0;
            i_load_m         = vecs[v].load;
            i_alu_result_m   = vecs[v].addr;
            i_mem_byte_sel_m = vecs[v].lanes;
            #1;
            check($sformatf("fwd%0d_mask", v), {28'h0, o_load_hit_mask}, {28'h0, vecs[v].exp_mask});
            check($sformatf("fwd%0d_data", v), o_load_hit_data, vecs[v].exp_data);
            check($sformatf("fwd%0d_stall", v), {31'h0, o_sb_stall}, {31'h0, vecs[v].exp_stall});
            @(negedge i_clk);
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) ack_one();

        // Partial hit stalls until the covering entry drains
        store(32'h0000_0300, 32'h0000_CAFE, 4'b0011);
        i_load_m         = 1'b1;
        i_alu_result_m   = 32'h0000_0300;
        i_mem_byte_sel_m = 4'hF;
        #1;
        check("partial_mask", {28'h0, o_load_hit_mask}, 32'h3);
        check("partial_data", o_load_hit_data, 32'h0000_CAFE);
        check("partial_stall", {31'h0, o_sb_stall}, 32'h1);
        @(negedge i_clk);
        ack_one();
        #1;
        check("partial_mask_drained", {28'h0, o_load_hit_mask}, 32'h0);
        check("partial_stall_drained", {31'h0, o_sb_stall}, 32'h0);
        @(negedge i_clk);
        idle_inputs();

        // Wrap-around: ten stores interleaved with acks
        for (int k = 0; k < 10; k++) begin
            logic [3:0] be_tab [10];
            be_tab = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h6, 4'h9, 4'hF};
            store(32'h0000_0400 + XL'(4 * k), 32'hA500_0000 | XL'(k * 32'h0101), be_tab[k]);
            if (k > 0) ack_one();
        end
        ack_one();
        check("wrap_empty_end", {31'h0, o_empty}, 32'h1);
        check("wrap_q_drained", 32'(exp_q.size()), 32'h0);
        repeat (3) @(negedge i_clk);
        check("wrap_no_req_end", {31'h0, o_bus_req}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
